regfile_sb: RTL and testbench

// - Parametrised multi-read, dual-write integer/FP register file with a per-entry busy scoreboard.
// - Sits in the decode/issue stage: read ports feed operand fetch, write ports take commit/writeback, reserve port marks destinations at issue.
// - After reset, a sweep FSM loads every entry (entries 1 and 2 get programmable values), so the array needs no reset fan-out.

---
 rtl/regfile_sb.sv | 115 +++++++++++
 tb/tb_regfile_sb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with a per-entry busy scoreboard and a post-reset init sweep.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data onto the read ports.
module regfile_sb #(
    parameter int           W       = 32,
    parameter int           DEPTH   = 64,
    parameter int           AW      = $clog2(DEPTH),
    parameter int           NRD     = 2,
    parameter logic [W-1:0] INIT_R1 = W'(32'hDEADBEEF),
    parameter logic [W-1:0] INIT_R2 = W'(32'h00400000)
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              ready,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*W-1:0]  rd,
    output logic [NRD-1:0]    rbusy,
    input  logic              we1,
    input  logic              we2,
    input  logic [AW-1:0]     wa1,
    input  logic [AW-1:0]     wa2,
    input  logic [W-1:0]      wd1,
    input  logic [W-1:0]      wd2,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_a
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [W-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [W-1:0]     init_val;
    logic             w1, w2, rs;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_INIT: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(DEPTH - 1)) state_d = S_RUN;
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    assign ready = (state_q == S_RUN);

    // Every port that changes state is masked until the sweep has finished.
    assign w1 = ready & we1;
    assign w2 = ready & we2;
    assign rs = ready & rsv_en;

    assign init_val = (idx_q == AW'(1)) ? INIT_R1 :
                      (idx_q == AW'(2)) ? INIT_R2 : '0;

    // No reset on the array: the sweep is the only initialiser. Port 1 is
    // written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[idx_q] <= init_val;
        end else begin
            if (w2) mem[wa2] <= wd2;
            if (w1) mem[wa1] <= wd1;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (w1) busy_d[wa1] = 1'b0;
        if (w2) busy_d[wa2] = 1'b0;
        if (rs) busy_d[rsv_a] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          clr, set;
        logic [W-1:0]  data;

        assign a   = ra[k*AW +: AW];
        assign clr = (w1 && wa1 == a) || (w2 && wa2 == a);
        assign set = rs && rsv_a == a;

        // Clears are forwarded; a same-cycle reservation only keeps an
        // already-busy entry from being shown as cleared.
        assign rbusy[k] = ready & busy_q[a] & ~(clr & ~set);

`ifdef REGFILE_BYPASS_EN
        assign data = (w1 && wa1 == a) ? wd1 :
                      (w2 && wa2 == a) ? wd2 : mem[a];
`else
        assign data = mem[a];
`endif

        assign rd[k*W +: W] = ready ? data : '0;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed table, multi-cycle reset sequences, random vs model.
module tb_regfile_sb;
    localparam int W = 32, DEPTH = 64, AW = 6, NRD = 4;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              ready;
    logic [NRD*AW-1:0] ra;
    logic [NRD*W-1:0]  rd;
    logic [NRD-1:0]    rbusy;
    logic              we1, we2, rsv_en;
    logic [AW-1:0]     wa1, wa2, rsv_a;
    logic [W-1:0]      wd1, wd2;

    always #5 clk = ~clk;

    regfile_sb #(.W(W), .DEPTH(DEPTH), .NRD(NRD)) dut (
        .clk(clk), .rstn(rstn), .ready(ready), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we1(we1), .we2(we2), .wa1(wa1), .wa2(wa2), .wd1(wd1), .wd2(wd2),
        .rsv_en(rsv_en), .rsv_a(rsv_a)
    );

    // reference model: entries swept so far, contents, busy flags
    int         m_fill;
    logic [W-1:0] m_mem [DEPTH];
    bit         m_busy [DEPTH];
    int         ncmp = 0, nfail = 0;

    function automatic logic [W-1:0] init_val(int i);
        return (i == 1) ? 32'hDEADBEEF : (i == 2) ? 32'h00400000 : 32'h0;
    endfunction

    function automatic logic [W-1:0] exp_rd(int a);
        if (m_fill < DEPTH) return '0;
        if (BYP && we1 && int'(wa1) == a) return wd1;
        if (BYP && we2 && int'(wa2) == a) return wd2;
        return m_mem[a];
    endfunction

    function automatic logic exp_rb(int a);
        if (m_fill < DEPTH) return 1'b0;
        if (rsv_en && int'(rsv_a) == a) return m_busy[a];
        if ((we1 && int'(wa1) == a) || (we2 && int'(wa2) == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_reset();
        m_fill = 0;
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    endtask

    task automatic tick();
        if (rstn) begin
            if (m_fill < DEPTH) begin
                m_mem[m_fill] = init_val(m_fill);
                m_fill++;
            end else begin
                if (we2) m_mem[wa2] = wd2;
                if (we1) m_mem[wa1] = wd1;
                if (we1) m_busy[wa1] = 1'b0;
                if (we2) m_busy[wa2] = 1'b0;
                if (rsv_en) m_busy[rsv_a] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("ready", {31'b0, ready}, {31'b0, m_fill == DEPTH});
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("rd%0d", k), rd[k*W +: W], exp_rd(int'(ra[k*AW +: AW])));
            check($sformatf("rbusy%0d", k), {31'b0, rbusy[k]}, {31'b0, exp_rb(int'(ra[k*AW +: AW]))});
        end
    endtask

    task automatic idle();
        we1 = 0; we2 = 0; rsv_en = 0;
        wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0; rsv_a = '0;
    endtask

    typedef struct {
        logic                  we1, we2, rsv_en;
        logic [AW-1:0]         wa1, wa2, rsv_a;
        logic [W-1:0]          wd1, wd2;
        logic [NRD-1:0][AW-1:0] ra;
        logic [NRD-1:0][W-1:0]  erd;
        logic [NRD-1:0]        erb;
    } vec_t;

    function automatic vec_t v1(logic e1, int a1, logic [W-1:0] d1, logic e2, int a2,
                                logic [W-1:0] d2, logic rs, int rsa, int r0,
                                logic [W-1:0] erd0, logic erb0);
        vec_t v;
        v.we1 = e1; v.wa1 = AW'(a1); v.wd1 = d1;
        v.we2 = e2; v.wa2 = AW'(a2); v.wd2 = d2;
        v.rsv_en = rs; v.rsv_a = AW'(rsa);
        v.ra  = {6'd3, 6'd2, 6'd1, AW'(r0)};
        v.erd = {32'h0, 32'h00400000, 32'hDEADBEEF, erd0};
        v.erb = {3'b000, erb0};
        return v;
    endfunction

    vec_t tbl [16];

    initial begin
        idle();
        ra = {6'd3, 6'd2, 6'd1, 6'd5};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_rd0", rd[W-1:0], 32'd0);
        check("reset_rbusy", {28'b0, rbusy}, 32'd0);

        // sweep with a write held on entry 5 the whole time
        we1 = 1; wa1 = 6'd5; wd1 = 32'h1;
        rstn = 1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("sweep_ready", {31'b0, ready}, 32'd0);
            check("sweep_rd0", rd[W-1:0], 32'd0);
            tick();
        end
        #1;
        check("ready_rise", {31'b0, ready}, 32'd1);
        check("e5_first_run", rd[W-1:0], BYP ? 32'h1 : 32'h0);
        idle();
        #1;
        check("e5_after_sweep", rd[W-1:0], 32'h0);

        tbl[0]  = v1(1, 7, 32'hAAAA5555, 0, 0, 0, 0, 0, 7, BYP ? 32'hAAAA5555 : 32'h0, 0);
        tbl[1]  = v1(0, 0, 0, 0, 0, 0, 0, 0, 7, 32'hAAAA5555, 0);
        tbl[2]  = v1(1, 9, 32'h1111, 1, 9, 32'h2222, 0, 0, 9, BYP ? 32'h1111 : 32'h0, 0);
        tbl[3]  = v1(0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h1111, 0);
        tbl[4]  = v1(0, 0, 0, 0, 0, 0, 1, 12, 12, 32'h0, 0);
        tbl[5]  = v1(0, 0, 0, 0, 0, 0, 0, 0, 12, 32'h0, 1);
        tbl[6]  = v1(0, 0, 0, 1, 12, 32'h55, 1, 12, 12, BYP ? 32'h55 : 32'h0, 1);
        tbl[7]  = v1(0, 0, 0, 0, 0, 0, 0, 0, 12, 32'h55, 1);
        tbl[8]  = v1(0, 0, 0, 1, 12, 32'h66, 0, 0, 12, BYP ? 32'h66 : 32'h55, 0);
        tbl[9]  = v1(0, 0, 0, 0, 0, 0, 0, 0, 12, 32'h66, 0);
        tbl[10] = v1(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
        tbl[11] = v1(0, 0, 0, 0, 0, 0, 0, 0, 2, 32'h00400000, 0);
        tbl[12] = v1(0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h0, 0);
        tbl[13] = v1(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        tbl[14] = v1(0, 0, 0, 0, 0, 0, 1, 63, 0, 32'h0, 0);
        tbl[14].ra  = {6'd63, 6'd9, 6'd2, 6'd1};
        tbl[14].erd = {32'h0, 32'h1111, 32'h00400000, 32'hDEADBEEF};
        tbl[14].erb = 4'b0000;
        tbl[15] = tbl[14];
        tbl[15].rsv_en = 0;
        tbl[15].erb = 4'b1000;

        for (int i = 0; i < 16; i++) begin
            we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
            we2 = tbl[i].we2; wa2 = tbl[i].wa2; wd2 = tbl[i].wd2;
            rsv_en = tbl[i].rsv_en; rsv_a = tbl[i].rsv_a;
            ra = tbl[i].ra;
            #1;
            for (int k = 0; k < NRD; k++) begin
                check($sformatf("tbl%0d_rd%0d", i, k), rd[k*W +: W], tbl[i].erd[k]);
                check($sformatf("tbl%0d_rb%0d", i, k), {31'b0, rbusy[k]}, {31'b0, tbl[i].erb[k]});
            end
            check_all();
            tick();
        end

        // random traffic on a narrow address window to force collisions
        for (int n = 0; n < 400; n++) begin
            we1 = 1'($urandom_range(0, 1));
            we2 = 1'($urandom_range(0, 1));
            rsv_en = ($urandom_range(0, 2) == 0);
            wa1 = AW'($urandom_range(0, 15));
            wa2 = AW'($urandom_range(0, 15));
            rsv_a = AW'($urandom_range(0, 15));
            wd1 = $urandom;
            wd2 = $urandom;
            for (int k = 0; k < NRD; k++) ra[k*AW +: AW] = AW'($urandom_range(0, 15));
            #1;
            check_all();
            tick();
        end

        // reserve 20, then reset twice, the second time mid-sweep at idx 30
        idle();
        rsv_en = 1; rsv_a = 6'd20;
        tick();
        idle();
        ra = {6'd3, 6'd2, 6'd1, 6'd20};
        #1;
        check("busy20_before_reset", {31'b0, rbusy[0]}, 32'd1);
        rstn = 0;
        model_reset();
        tick();
        rstn = 1;
        for (int i = 0; i < 30; i++) tick();
        rstn = 0;
        model_reset();
        #1;
        check("midsweep_ready", {31'b0, ready}, 32'd0);
        check("midsweep_rbusy", {28'b0, rbusy}, 32'd0);
        tick();
        rstn = 1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("resweep_ready", {31'b0, ready}, 32'd0);
            tick();
        end
        #1;
        check("resweep_ready_rise", {31'b0, ready}, 32'd1);
        check("busy20_cleared", {31'b0, rbusy[0]}, 32'd0);
        check("resweep_e1", rd[W +: W], 32'hDEADBEEF);
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
